// File: rtl/batalha_pkg.sv
// Shared types for the battleship board: ship codes, lengths,
// board size, cell codes and the placement sequencer states.
package batalha_pkg;

  localparam int BOARD_N = 10;
  localparam logic [2:0] EMPTY = 3'd0;

  localparam logic [2:0] T_SUBMARINO   = 3'd0;
  localparam logic [2:0] T_CRUZADOR    = 3'd1;
  localparam logic [2:0] T_HIDROAVIAO  = 3'd2;
  localparam logic [2:0] T_ENCOURACADO = 3'd3;
  localparam logic [2:0] T_PORTAAVIOES = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CHECK,
    S_WAIT,
    S_WRITE,
    S_DONE
  } estado_t;

  typedef struct packed {
    logic       jogador;
    logic [2:0] tipo;
    logic       direcao;
    logic [3:0] x;
    logic [3:0] y;
  } pedido_t;

  function automatic logic [2:0] comprimento_embarcacao(
    input logic [2:0] tipo
  );
    logic [2:0] l;
    case (tipo)
      T_SUBMARINO:   l = 3'd1;
      T_CRUZADOR:    l = 3'd2;
      T_HIDROAVIAO:  l = 3'd3;
      T_ENCOURACADO: l = 3'd4;
      T_PORTAAVIOES: l = 3'd5;
      default:       l = 3'd0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/enderecador_celula.sv
// Cell address of the k-th segment of a ship:
// {jogador, y, x} with k added along the ship direction.
module enderecador_celula #(
  parameter int AW = 9
) (
  input  logic          jogador,
  input  logic          direcao,
  input  logic [3:0]    x,
  input  logic [3:0]    y,
  input  logic [2:0]    k,
  output logic [AW-1:0] addr
);

  logic [3:0] xx;
  logic [3:0] yy;

  always_comb begin
    xx = x;
    yy = y;
    if (direcao) yy = y + {1'b0, k};
    else         xx = x + {1'b0, k};
  end

  assign addr = AW'({jogador, yy, xx});

endmodule

// File: rtl/gravador_embarcacao.sv
// Ship placement sequencer: bounds check, overlap read pass,
// then write pass over the shared board memory.
module gravador_embarcacao #(
  parameter int BOARD_N = 10,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          jogador,
  input  logic [2:0]    tipo,
  input  logic          direcao,
  input  logic [3:0]    x,
  input  logic [3:0]    y,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  input  logic [2:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [2:0]    mem_wr_data,
  output logic          busy,
  output logic          done,
  output logic          conflito
);

  import batalha_pkg::*;

  localparam logic [4:0] LIM = 5'(BOARD_N);

  estado_t    state, nxt;
  pedido_t    ped;
  logic [2:0] len_r;
  logic [2:0] k;
  logic       flag;
  logic       rd_pend;
  logic       conf_r;

  logic [2:0]    len_in;
  logic [4:0]    fim;
  logic          bad;
  logic          hit;
  logic          strobe;
  logic [2:0]    last;
  logic [AW-1:0] addr_c;

  assign len_in = comprimento_embarcacao(tipo);
  assign fim    = (direcao ? {1'b0, y} : {1'b0, x})
                + {2'b0, len_in} - 5'd1;

  // Origin and end are checked in 5 bits so x+L-1 cannot wrap.
  assign bad = (tipo > T_PORTAAVIOES)
             | ({1'b0, x} >= LIM)
             | ({1'b0, y} >= LIM)
             | (fim >= LIM);

  assign hit    = rd_pend & (mem_rd_data != EMPTY);
  assign strobe = mem_rd_en | mem_wr_en;
  assign last   = len_r - 3'd1;

  enderecador_celula #(.AW(AW)) u_end (
    .jogador (ped.jogador),
    .direcao (ped.direcao),
    .x       (ped.x),
    .y       (ped.y),
    .k       (k),
    .addr    (addr_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = bad ? S_DONE : S_REQ;
      S_REQ:   if (mem_gnt) nxt = S_CHECK;
      S_CHECK: if (mem_rd_en && k == last) nxt = S_WAIT;
      S_WAIT:  nxt = (flag | hit) ? S_DONE : S_WRITE;
      S_WRITE: if (mem_wr_en && k == last) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 3'd0;
    mem_addr    = '0;
    unique case (1'b1)
      state == S_REQ,
      state == S_WAIT: mem_req = 1'b1;
      state == S_CHECK: begin
        mem_req   = 1'b1;
        mem_rd_en = mem_gnt;
        mem_addr  = addr_c;
      end
      state == S_WRITE: begin
        mem_req     = 1'b1;
        mem_wr_en   = mem_gnt;
        mem_wr_data = ped.tipo + 3'd1;
        mem_addr    = addr_c;
      end
      default: ;
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign conflito = conf_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped     <= '0;
      len_r   <= 3'd0;
      k       <= 3'd0;
      flag    <= 1'b0;
      rd_pend <= 1'b0;
      conf_r  <= 1'b0;
    end else begin
      rd_pend <= mem_rd_en;
      if (state == S_IDLE && start) begin
        ped    <= '{jogador, tipo, direcao, x, y};
        len_r  <= len_in;
        conf_r <= bad;
        flag   <= 1'b0;
      end else if (hit) begin
        flag <= 1'b1;
      end
      if (state == S_WAIT && (flag | hit)) conf_r <= 1'b1;
      // k holds across a dropped grant, restarts between passes
      if (strobe) k <= k + 3'd1;
      else if (state != S_CHECK && state != S_WRITE) k <= 3'd0;
    end
  end

endmodule
